// File: rtl/pcie_tl_pkg.sv
// Shared types and constants for the transaction-layer VC blocks.
// Used by vc_demux and its skid2 buffer.
package pcie_tl_pkg;

  localparam int DATA_W = 12;
  localparam int VC_W   = 2;
  localparam int VC_LSB = 10;
  localparam int CNT_W  = 16;
  localparam int NUM_VC = 4;

  typedef logic [VC_W-1:0] vc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } occ_state_t;

  function automatic vc_t get_vc(input logic [DATA_W-1:0] word);
    return word[VC_LSB+VC_W-1:VC_LSB];
  endfunction

endpackage

// File: rtl/skid2.sv
// Two-entry in-order buffer that holds words waiting behind a blocked egress VC.
// The caller never writes it when full or reads it when empty.
module skid2
  import pcie_tl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr) wr_ptr <= ~wr_ptr;
      if (rd) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, wr} - {1'b0, rd};
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/vc_demux.sv
// Routes words from one ingress FIFO to four per-VC egress FIFOs in arrival order.
// Define VC_DEMUX_COUNT_EN to add per-VC push counters cnt_0..3.
module vc_demux
  import pcie_tl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              empty_in,
  input  logic              almost_empty_in,
  output logic              pop_in,
  input  logic              almost_full_0,
  input  logic              almost_full_1,
  input  logic              almost_full_2,
  input  logic              almost_full_3,
  output logic              push_0,
  output logic              push_1,
  output logic              push_2,
  output logic              push_3,
  output logic [DATA_W-1:0] data_out,
  output logic              idle
`ifdef VC_DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_0,
  output logic [CNT_W-1:0]  cnt_1,
  output logic [CNT_W-1:0]  cnt_2,
  output logic [CNT_W-1:0]  cnt_3
`endif
);

  logic              rd_pend;
  logic [NUM_VC-1:0] af;
  logic [NUM_VC-1:0] push_q;
  logic              skid_wr;
  logic              skid_rd;
  logic              skid_valid;
  logic [1:0]        skid_count;
  logic [DATA_W-1:0] skid_dout;
  logic [DATA_W-1:0] head_word;
  logic              head_valid;
  logic              drain;
  vc_t               head_vc;
  logic [1:0]        occ;
  logic [2:0]        occ_sum;
  logic              pop_next;
  occ_state_t        state;
  occ_state_t        state_next;

  assign af = {almost_full_3, almost_full_2, almost_full_1, almost_full_0};

  skid2 u_skid (
    .clk   (clk),
    .reset (reset),
    .wr    (skid_wr),
    .rd    (skid_rd),
    .din   (data_in),
    .dout  (skid_dout),
    .valid (skid_valid),
    .count (skid_count)
  );

  // An empty skid lets the word arriving this cycle drain straight through,
  // which is what sustains one word per cycle.
  always_comb begin
    head_valid = (skid_count != 2'd0) | rd_pend;
    head_word  = skid_valid ? skid_dout : data_in;
    head_vc    = get_vc(head_word);
    drain      = head_valid & ~af[head_vc];
    skid_rd    = drain & skid_valid;
    skid_wr    = rd_pend & ~(drain & ~skid_valid);
    occ        = state;
    occ_sum    = {1'b0, occ} - {2'b0, drain} + {2'b0, pop_in};
    pop_next   = ~empty_in & (occ_sum < 3'd2) & ~(pop_in & almost_empty_in);
    case (occ_sum[1:0])
      2'd0:    state_next = ST_IDLE;
      2'd1:    state_next = ST_FILL;
      default: state_next = ST_FULL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rd_pend  <= 1'b0;
      pop_in   <= 1'b0;
      push_q   <= '0;
      data_out <= '0;
      idle     <= 1'b1;
    end else begin
      state   <= state_next;
      rd_pend <= pop_in;
      pop_in  <= pop_next;
      push_q  <= drain ? ({{(NUM_VC-1){1'b0}}, 1'b1} << head_vc) : '0;
      if (drain) data_out <= head_word;
      idle    <= (state_next == ST_IDLE) & ~pop_next;
    end
  end

  assign push_0 = push_q[0];
  assign push_1 = push_q[1];
  assign push_2 = push_q[2];
  assign push_3 = push_q[3];

`ifdef VC_DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt [NUM_VC];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_VC; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_VC; k++)
        if (push_q[k]) cnt[k] <= cnt[k] + 1'b1;
    end
  end

  assign cnt_0 = cnt[0];
  assign cnt_1 = cnt[1];
  assign cnt_2 = cnt[2];
  assign cnt_3 = cnt[3];
`endif

endmodule

// File: tb/tb_vc_demux.sv
// Self-checking bench for vc_demux: routing table, backpressure, last word, reset, random traffic.
// Counter checks run only when VC_DEMUX_COUNT_EN is defined.
module tb_vc_demux;
  import pcie_tl_pkg::*;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic              empty_in;
  logic              almost_empty_in;
  logic              pop_in;
  logic [3:0]        af;
  logic              push_0, push_1, push_2, push_3;
  logic [DATA_W-1:0] data_out;
  logic              idle;
`ifdef VC_DEMUX_COUNT_EN
  logic [CNT_W-1:0]  cnt_0, cnt_1, cnt_2, cnt_3;
`endif

  vc_demux dut (
    .clk             (clk),
    .reset           (reset),
    .data_in         (data_in),
    .empty_in        (empty_in),
    .almost_empty_in (almost_empty_in),
    .pop_in          (pop_in),
    .almost_full_0   (af[0]),
    .almost_full_1   (af[1]),
    .almost_full_2   (af[2]),
    .almost_full_3   (af[3]),
    .push_0          (push_0),
    .push_1          (push_1),
    .push_2          (push_2),
    .push_3          (push_3),
    .data_out        (data_out),
    .idle            (idle)
`ifdef VC_DEMUX_COUNT_EN
    ,
    .cnt_0           (cnt_0),
    .cnt_1           (cnt_1),
    .cnt_2           (cnt_2),
    .cnt_3           (cnt_3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] word;
    logic [3:0]        exp_push;
  } vec_t;

  // Ingress FIFO contents, and words popped but not yet seen on egress (arrival order).
  logic [DATA_W-1:0] ing_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int                vc_cnt[4];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                cycle    = 0;
  int                n_pops   = 0;
  int                n_pushes = 0;

  function automatic logic [3:0] push_vec();
    return {push_3, push_2, push_1, push_0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic refreshFlags();
    empty_in        = (ing_q.size() == 0);
    almost_empty_in = (ing_q.size() <= 1);
  endtask

  // One clock: models the ingress FIFO and scores every egress push against arrival order.
  task automatic applyStimulus();
    logic       p;
    logic       r;
    logic [3:0] af_s;
    logic [3:0] pv;
    logic [DATA_W-1:0] w;
    int         k;
    p    = (pop_in === 1'b1);
    r    = reset;
    af_s = af;
    @(posedge clk);
    #1;
    cycle++;
    if (r) begin
      exp_q.delete();
      for (int i = 0; i < 4; i++) vc_cnt[i] = 0;
    end
    if (p) begin
      n_pops++;
      checkOutput("no_underflow", ing_q.size() != 0, 1);
      if (ing_q.size() != 0) begin
        data_in = ing_q.pop_front();
        if (!r) exp_q.push_back(data_in);
      end
    end
    refreshFlags();
    pv = push_vec();
    if (r) begin
      checkOutput("reset_push", pv, 0);
      checkOutput("reset_pop", pop_in, 0);
      checkOutput("reset_idle", idle, 1);
      checkOutput("reset_data", data_out, 0);
    end else if (pv != 0) begin
      n_pushes++;
      k = 0;
      for (int i = 0; i < 4; i++) if (pv[i]) k = i;
      checkOutput("push_onehot", $countones(pv), 1);
      checkOutput("push_af_low", af_s[k], 0);
      checkOutput("push_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        checkOutput("push_data", data_out, w);
        checkOutput("push_vc", k, w[VC_LSB+1:VC_LSB]);
        vc_cnt[k] = (vc_cnt[k] + 1) % (1 << CNT_W);
      end
    end
  endtask

  task automatic checkCounters(input string tag);
`ifdef VC_DEMUX_COUNT_EN
    // counters update one cycle after the push is visible
    applyStimulus();
    checkOutput({tag, "_cnt0"}, cnt_0, vc_cnt[0]);
    checkOutput({tag, "_cnt1"}, cnt_1, vc_cnt[1]);
    checkOutput({tag, "_cnt2"}, cnt_2, vc_cnt[2]);
    checkOutput({tag, "_cnt3"}, cnt_3, vc_cnt[3]);
`else
    if (tag.len() < 0) applyStimulus();
`endif
  endtask

  initial begin
    vec_t tbl[8];
    int   first_pop;
    int   pops0;
    int   n_left;
    int   any_push;
    int   budget;
    logic [3:0]        obs_push[$];
    logic [DATA_W-1:0] obs_data[$];
    int                obs_cyc[$];

    tbl[0] = '{12'h000, 4'b0001};
    tbl[1] = '{12'h4AB, 4'b0010};
    tbl[2] = '{12'h8CD, 4'b0100};
    tbl[3] = '{12'hFFF, 4'b1000};
    tbl[4] = '{12'h3FF, 4'b0001};
    tbl[5] = '{12'h400, 4'b0010};
    tbl[6] = '{12'hBAD, 4'b0100};
    tbl[7] = '{12'hC01, 4'b1000};

    reset   = 1'b1;
    af      = 4'b0000;
    data_in = '0;
    for (int i = 0; i < 8; i++) ing_q.push_back(tbl[i].word);
    refreshFlags();

    // Reset held two cycles with a non-empty ingress FIFO
    $display("[TB] reset");
    applyStimulus();
    applyStimulus();
    checkOutput("reset_no_pops", n_pops, 0);
    reset = 1'b0;

    // Routing: one push per cycle, two cycles after the first pop
    $display("[TB] routing");
    first_pop = -1;
    for (int c = 0; c < 20; c++) begin
      applyStimulus();
      if (pop_in && first_pop < 0) first_pop = cycle;
      if (push_vec() != 0) begin
        obs_push.push_back(push_vec());
        obs_data.push_back(data_out);
        obs_cyc.push_back(cycle);
      end
    end
    checkOutput("route_count", obs_push.size(), 8);
    for (int i = 0; i < 8 && i < obs_push.size(); i++) begin
      checkOutput("route_push", obs_push[i], tbl[i].exp_push);
      checkOutput("route_data", obs_data[i], tbl[i].word);
      checkOutput("route_latency", obs_cyc[i] - first_pop, 2 + i);
    end
    checkOutput("route_idle", idle, 1);
    checkCounters("route");

    // Backpressure on VC2 blocks 0x800 and, behind it, 0x001
    $display("[TB] backpressure");
    af = 4'b0100;
    ing_q.push_back(12'h800);
    ing_q.push_back(12'h001);
    refreshFlags();
    any_push = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus();
      if (push_vec() != 0) any_push = 1;
    end
    checkOutput("hol_no_push", any_push, 0);
    checkOutput("hol_pop_stopped", pop_in, 0);
    checkOutput("hol_fifo_drained", ing_q.size(), 0);
    checkOutput("hol_not_idle", idle, 0);
    af = 4'b0000;
    applyStimulus();
    checkOutput("release_push2", push_vec(), 4'b0100);
    checkOutput("release_data2", data_out, 12'h800);
    applyStimulus();
    checkOutput("release_push0", push_vec(), 4'b0001);
    checkOutput("release_data0", data_out, 12'h001);
    applyStimulus();
    checkOutput("release_idle", idle, 1);

    // Last ingress word: exactly one pop
    $display("[TB] last word");
    pops0 = n_pops;
    ing_q.push_back(12'h123);
    refreshFlags();
    for (int c = 0; c < 10; c++) applyStimulus();
    checkOutput("last_word_pops", n_pops - pops0, 1);
    checkOutput("last_word_idle", idle, 1);
    checkOutput("last_word_scoreboard", exp_q.size(), 0);

    // Reset while two words are in flight; they must never appear
    $display("[TB] reset mid-stream");
    af = 4'b1111;
    ing_q.push_back(12'h111);
    ing_q.push_back(12'h522);
    ing_q.push_back(12'h933);
    ing_q.push_back(12'hD44);
    refreshFlags();
    for (int c = 0; c < 6; c++) applyStimulus();
    checkOutput("pre_reset_pop_stopped", pop_in, 0);
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    af = 4'b0000;
    n_left = ing_q.size();
    pops0 = n_pushes;
    for (int c = 0; c < 12; c++) applyStimulus();
    checkOutput("post_reset_pushes", n_pushes - pops0, n_left);
    checkOutput("post_reset_idle", idle, 1);
    checkCounters("post_reset");

    // Random traffic and backpressure against the scoreboard
    $display("[TB] random");
    for (int c = 0; c < 400; c++) begin
      af = 4'b0000;
      for (int k = 0; k < 4; k++) af[k] = ($urandom_range(3) == 0);
      reset = (c == 200);
      applyStimulus();
      if (ing_q.size() < 5 && $urandom_range(1) == 1) begin
        ing_q.push_back(DATA_W'($urandom));
        refreshFlags();
      end
    end
    reset = 1'b0;
    af = 4'b0000;
    budget = 0;
    while (!(idle && exp_q.size() == 0 && ing_q.size() == 0) && budget < 60) begin
      applyStimulus();
      budget++;
    end
    checkOutput("random_drained", idle && exp_q.size() == 0 && ing_q.size() == 0, 1);
    checkCounters("random");

`ifdef VC_DEMUX_COUNT_EN
    // 65537 VC1 words: counter wraps to 1
    $display("[TB] counter wrap");
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    pops0 = n_pushes;
    budget = 0;
    begin
      int fed;
      fed = 0;
      while ((n_pushes - pops0) < 65537 && budget < 70000) begin
        if (fed < 65537 && ing_q.size() < 4) begin
          ing_q.push_back(12'h400 | DATA_W'(fed & 10'h3FF));
          fed++;
          refreshFlags();
        end
        applyStimulus();
        budget++;
      end
    end
    checkOutput("wrap_pushes", n_pushes - pops0, 65537);
    applyStimulus();
    checkOutput("wrap_cnt1", cnt_1, 65537 % (1 << CNT_W));
    checkOutput("wrap_cnt0", cnt_0, 0);
    checkOutput("wrap_cnt2", cnt_2, 0);
    checkOutput("wrap_cnt3", cnt_3, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
